sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-port arbiter that shares the board's single asynchronous 16-bit SRAM between the CPU memory interface (MAR/MDR path driven by the control unit) and a secondary requester (debug/DMA loader). Each granted access is sequenced as a fixed two-cycle SRAM strobe window plus one acknowledge cycle. Active-low SRAM strobes are generated here, so requesters never touch the chip pins. It sits between the CPU datapath's memory port and the top-level SRAM pins.

## Interface
- ADDR_W, 20: SRAM address width.
- DATA_W, 16: SRAM data width.

- Clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high.
- Req0, Req1  in  1 each  request; port 0 is CPU, port 1 is secondary.
- We0, We1  in  1 each  1 = write, 0 = read; qualified by ReqN.
- Addr0, Addr1  in  ADDR_W each  access address.
- Wdata0, Wdata1  in  DATA_W each  write data.
- Ack0, Ack1  out  1 each  one-cycle completion pulse.
- Rdata  out  DATA_W  read data; valid while AckN is high.
- Mem_ADDR  out  ADDR_W  SRAM address.
- Mem_Dout  out  DATA_W  data toward SRAM.
- Mem_Dout_EN  out  1  tristate enable for Mem_Dout; the top level owns the pad buffer.
- Mem_Din  in  DATA_W  data from SRAM.
- Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.

## Operation
- States: IDLE, ACC1, ACC2, DONE.
- IDLE: if any ReqN is high, select a winner, latch its Addr/We/Wdata and the port index, then go to ACC1. Otherwise stay in IDLE.
- ACC1 goes to ACC2. ACC2 goes to DONE. DONE goes to IDLE, with no exceptions.
- Strobes:
  - Mem_CE, Mem_UB and Mem_LB are 0 in ACC1 and ACC2, and 1 otherwise.
  - For a read, Mem_OE is 0 in ACC1 and ACC2.
  - For a write, Mem_WE is 0 in ACC1 and ACC2, and Mem_Dout_EN is 1 in ACC1 and ACC2.
- Mem_ADDR holds the latched address from ACC1 through DONE.
- Read capture: Mem_Din is registered into Rdata on the ACC2→DONE edge. Rdata holds that value until the next read capture.
- Ack: the winning AckN is 1 in DONE only; the other Ack stays 0.
- Requester rule: Addr, We and Wdata must be stable from request until Ack. If ReqN is still high in the IDLE cycle after DONE, it is a new request.
- Arbitration: round-robin, see Configuration.
- Simultaneous requests: exactly one port is granted. The loser keeps its request and is served in the next IDLE.
- Invariant: at most one of Mem_OE and Mem_WE is low in any cycle.
- Invariant: Mem_WE returns high for at least one cycle (DONE) between back-to-back writes.

## Timing
- Request sampled in IDLE at edge 0, then ACC1 at cycle 1, ACC2 at cycle 2, Ack at cycle 3. Earliest next access starts at ACC1 in cycle 5.
- Sustained throughput: one access per 4 cycles.
- Reset values:
  - State = IDLE.
  - Ack0 = Ack1 = 0.
  - Rdata = 0, Mem_ADDR = 0, Mem_Dout = 0, Mem_Dout_EN = 0.
  - All strobes = 1.
  - Last-granted = port 1, so port 0 wins the first tie.
- Reset mid-access: from the cycle after the reset edge, all strobes are deasserted and Mem_Dout_EN = 0. No Ack is issued for the aborted access. The requester must re-request.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin arbitration. On a tie, the port not granted last wins. Last-granted updates on every grant.
- SRAM_ARB_RR_EN undefined: fixed priority, port 0 (CPU) always wins a tie. The last-granted register is not built.
- All other behaviour is identical in both builds.

## Structure
- Package sram_arb_pkg holds:
  - the state enum (IDLE, ACC1, ACC2, DONE);
  - port index constants PORT_CPU = 0 and PORT_AUX = 1;
  - default widths SRAM_ADDR_W = 20 and SRAM_DATA_W = 16.
- One sub-module, sram_arb_pick: combinational winner select from Req0, Req1 and last-granted (round-robin or fixed).
- Latch registers, state register and strobe decode stay in sram_arbiter.

## Test plan
- Single read, port 0: Addr0 = 0x00010, Mem_Din = 0xBEEF in ACC2 -> Mem_OE low for exactly 2 cycles; Ack0 at cycle 3 with Rdata = 0xBEEF; Ack1 stays 0.
- Single write, port 1: Addr1 = 0x0FFFF, Wdata1 = 0x1234 -> Mem_WE low for 2 cycles; Mem_Dout = 0x1234 and Mem_Dout_EN = 1 in those cycles; Mem_ADDR = 0x0FFFF; Ack1 at cycle 3.
- Simultaneous Req0 and Req1 held high, round-robin build -> grants alternate 0, 1, 0, 1, one Ack every 4 cycles. Fixed-priority build -> port 0 only while Req0 is held.
- Back-to-back writes from port 0 to 0x00001 then 0x00002 -> Mem_WE high in the DONE cycle between the two; never OE and WE low together.
- Reset asserted during ACC1 of a write -> the next cycle has all strobes = 1, Mem_Dout_EN = 0, no Ack; a later request completes normally in 4 cycles.
- Req0 still held in the cycle after Ack0 -> treated as a second access, which completes with a second Ack0 4 cycles later.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared state encoding, port indices and default widths for the SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W = 20;
    localparam int unsigned SRAM_DATA_W = 16;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAcc1,
        StAcc2,
        StDone
    } sram_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational winner select between the CPU and auxiliary requesters.
// Round-robin on ties when SRAM_ARB_RR_EN is defined, otherwise fixed priority to the CPU.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
`ifdef SRAM_ARB_RR_EN
    input  logic i_last,
`endif
    output logic o_valid,
    output logic o_port
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_port  = PORT_CPU;
        if (i_req0 && i_req1) begin
`ifdef SRAM_ARB_RR_EN
            // The port that did not win last time takes the tie.
            o_port = ~i_last;
`else
            o_port = PORT_CPU;
`endif
        end else if (i_req1) begin
            o_port = PORT_AUX;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one asynchronous SRAM between the CPU and an auxiliary port; each grant
// runs a two-cycle strobe window plus an ack cycle. SRAM_ARB_RR_EN selects round-robin arbitration.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = SRAM_ADDR_W,
    parameter int unsigned DATA_W = SRAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_dout,
    output logic              o_mem_dout_en,
    input  logic [DATA_W-1:0] i_mem_din,
    output logic              o_mem_ce,
    output logic              o_mem_ub,
    output logic              o_mem_lb,
    output logic              o_mem_oe,
    output logic              o_mem_we
);

    sram_state_e       r_state;
    sram_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_we;
    logic              r_port;
    logic              w_valid;
    logic              w_port;
    logic              w_grant;
    logic              w_active;

    assign w_grant = (r_state == StIdle) && w_valid;

`ifdef SRAM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last <= PORT_AUX;
        end else if (w_grant) begin
            r_last <= w_port;
        end
    end
`endif

    sram_arb_pick u_pick (
        .i_req0  (i_req0),
        .i_req1  (i_req1),
`ifdef SRAM_ARB_RR_EN
        .i_last  (r_last),
`endif
        .o_valid (w_valid),
        .o_port  (w_port)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (w_valid) w_state_nxt = StAcc1;
            StAcc1: w_state_nxt = StAcc2;
            StAcc2: w_state_nxt = StDone;
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // The winner's request fields are frozen here for the whole access.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_port  <= PORT_CPU;
        end else if (w_grant) begin
            r_port  <= w_port;
            r_addr  <= (w_port == PORT_AUX) ? i_addr1  : i_addr0;
            r_wdata <= (w_port == PORT_AUX) ? i_wdata1 : i_wdata0;
            r_we    <= (w_port == PORT_AUX) ? i_we1    : i_we0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else if ((r_state == StAcc2) && !r_we) begin
            r_rdata <= i_mem_din;
        end
    end

    always_comb begin
        w_active      = (r_state == StAcc1) || (r_state == StAcc2);
        o_mem_ce      = ~w_active;
        o_mem_ub      = ~w_active;
        o_mem_lb      = ~w_active;
        o_mem_oe      = ~(w_active & ~r_we);
        o_mem_we      = ~(w_active & r_we);
        o_mem_dout_en = w_active & r_we;
        o_mem_addr    = r_addr;
        o_mem_dout    = r_wdata;
        o_rdata       = r_rdata;
        o_ack0        = (r_state == StDone) && (r_port == PORT_CPU);
        o_ack1        = (r_state == StDone) && (r_port == PORT_AUX);
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: scoreboard bench for sram_arbiter with a transaction-level arbitration model
// and a behavioural SRAM; builds with or without SRAM_ARB_RR_EN.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            ack_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr [2];
    logic [DW-1:0] wdata [2];
    logic          o_ack0, o_ack1;
    logic [DW-1:0] o_rdata;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_dout;
    logic          o_mem_dout_en;
    logic [DW-1:0] i_mem_din;
    logic          o_mem_ce, o_mem_ub, o_mem_lb, o_mem_oe, o_mem_we;

    exp_t          exp_q [$];
    txn_t          next_q0 [$];
    txn_t          next_q1 [$];
    logic [DW-1:0] sram [int];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] rd_hold = '0;
    int            n_checks = 0;
    int            n_pass = 0;
    int            cyc = 0;
    int            wait_cnt = 0;
    int            inflight = -1;
`ifdef SRAM_ARB_RR_EN
    logic          last = 1'b1;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_arbiter dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_req0        (req[0]),
        .i_req1        (req[1]),
        .i_we0         (we[0]),
        .i_we1         (we[1]),
        .i_addr0       (addr[0]),
        .i_addr1       (addr[1]),
        .i_wdata0      (wdata[0]),
        .i_wdata1      (wdata[1]),
        .o_ack0        (o_ack0),
        .o_ack1        (o_ack1),
        .o_rdata       (o_rdata),
        .o_mem_addr    (o_mem_addr),
        .o_mem_dout    (o_mem_dout),
        .o_mem_dout_en (o_mem_dout_en),
        .i_mem_din     (i_mem_din),
        .o_mem_ce      (o_mem_ce),
        .o_mem_ub      (o_mem_ub),
        .o_mem_lb      (o_mem_lb),
        .o_mem_oe      (o_mem_oe),
        .o_mem_we      (o_mem_we)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_val);
        n_checks++;
        if (act === req_val) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req_val, cyc);
    endtask

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[15:0] ^ 16'h5A3C;
    endfunction

    function automatic logic [DW-1:0] rd_sram(input logic [AW-1:0] a);
        if (sram.exists(int'(a))) return sram[int'(a)];
        return init_val(a);
    endfunction

    function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = w;
        t.addr = a;
        t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 47));
        if ($urandom_range(0, 7) == 0) a[AW-1:AW-4] = 4'hF;
        return mk(1'($urandom_range(0, 1)), a, DW'($urandom));
    endfunction

    task automatic push(input int p, input txn_t t);
        if (p == 0) next_q0.push_back(t);
        else next_q1.push_back(t);
    endtask

    task automatic pop_next(input int p, output bit got, output txn_t t);
        got = 1'b0;
        t = mk(1'b0, '0, '0);
        if (p == 0 && next_q0.size() > 0) begin
            t = next_q0.pop_front();
            got = 1'b1;
        end else if (p == 1 && next_q1.size() > 0) begin
            t = next_q1.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic start_txn(input int p, input txn_t t);
        req[p]   = 1'b1;
        we[p]    = t.we;
        addr[p]  = t.addr;
        wdata[p] = t.wdata;
    endtask

    // Reference arbitration: one access every four edges, winner chosen by the tie rule.
    task automatic grant();
        exp_t e;
        int   w;
        if (req[0] && req[1]) begin
`ifdef SRAM_ARB_RR_EN
            w = (last == 1'b0) ? 1 : 0;
`else
            w = 0;
`endif
        end else begin
            w = req[1] ? 1 : 0;
        end
        e.port    = w[0];
        e.we      = we[w];
        e.addr    = addr[w];
        e.wdata   = wdata[w];
        e.rdata   = e.we ? '0 : rd_ref(e.addr);
        e.ack_cyc = cyc + 3;
        if (e.we) ref_mem[int'(e.addr)] = e.wdata;
        exp_q.push_back(e);
`ifdef SRAM_ARB_RR_EN
        last = w[0];
`endif
        inflight = w;
        wait_cnt = 4;
    endtask

    task automatic step(input bit rnd);
        txn_t t;
        bit   got;
        int   w;
        @(negedge clk);
        if (wait_cnt > 0) wait_cnt--;
        if (wait_cnt == 0 && inflight >= 0) begin
            w = inflight;
            inflight = -1;
            pop_next(w, got, t);
            if (!got && rnd && $urandom_range(0, 2) == 0) begin
                t = rand_txn();
                got = 1'b1;
            end
            if (got) start_txn(w, t);
            else req[w] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            if (!req[p]) begin
                pop_next(p, got, t);
                if (!got && rnd && $urandom_range(0, 3) == 0) begin
                    t = rand_txn();
                    got = 1'b1;
                end
                if (got) start_txn(p, t);
            end
        end
        if (wait_cnt == 0 && (req[0] || req[1])) grant();
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || req != 2'b00 || next_q0.size() > 0 || next_q1.size() > 0
                || inflight >= 0) && n < 400) begin
            step(1'b0);
            n++;
        end
        chk("drain_done", 32'(n < 400), 32'd1);
        step(1'b0);
    endtask

    // SRAM: read data becomes valid only on the second cycle of the output-enable window.
    initial begin : sram_model
        int ph = 0;
        i_mem_din = '0;
        forever begin
            @(negedge clk);
            if (!o_mem_we && !o_mem_ce) sram[int'(o_mem_addr)] = o_mem_dout;
            if (!o_mem_oe && !o_mem_ce) begin
                ph++;
                i_mem_din = (ph >= 2) ? rd_sram(o_mem_addr) : DW'($urandom);
            end else begin
                ph = 0;
                i_mem_din = DW'($urandom);
            end
        end
    end

    initial begin : monitor
        exp_t e;
        int   win = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                win = 0;
                continue;
            end
            chk("oe_we_exclusive", 32'(o_mem_oe | o_mem_we), 32'd1);
            if (exp_q.size() > 0 && exp_q[0].ack_cyc < cyc) begin
                chk("ack_missing", 32'(cyc), 32'(exp_q[0].ack_cyc));
                void'(exp_q.pop_front());
                win = 0;
            end
            if (!o_mem_ce) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'(o_mem_ce), 32'd1);
                end else begin
                    e = exp_q[0];
                    win++;
                    chk("win_cycle", 32'(e.ack_cyc - cyc), 32'(3 - win));
                    chk("mem_addr", 32'(o_mem_addr), 32'(e.addr));
                    chk("ub_lb", 32'({o_mem_ub, o_mem_lb}), 32'd0);
                    chk("oe", 32'(o_mem_oe), 32'(e.we));
                    chk("we", 32'(o_mem_we), 32'(!e.we));
                    chk("dout_en", 32'(o_mem_dout_en), 32'(e.we));
                    if (e.we) chk("dout", 32'(o_mem_dout), 32'(e.wdata));
                end
            end else begin
                chk("idle_strobes", 32'({o_mem_oe, o_mem_we, o_mem_ub, o_mem_lb, o_mem_dout_en}),
                    32'(5'b11110));
            end
            if (o_ack0 || o_ack1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'({o_ack1, o_ack0}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_port", 32'({o_ack1, o_ack0}), e.port ? 32'd2 : 32'd1);
                    chk("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
                    chk("window_len", 32'(win), 32'd2);
                    chk("done_addr", 32'(o_mem_addr), 32'(e.addr));
                    if (!e.we) rd_hold = e.rdata;
                    chk("rdata", 32'(o_rdata), 32'(rd_hold));
                end
                win = 0;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far",
                 n_pass, n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1;
        req   = 2'b00;
        we    = 2'b00;
        for (int p = 0; p < 2; p++) begin
            addr[p]  = '0;
            wdata[p] = '0;
        end
        sram[16]    = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'({o_ack1, o_ack0}), 32'd0);
        chk("rst_rdata", 32'(o_rdata), 32'd0);
        chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
        chk("rst_dout", 32'(o_mem_dout), 32'd0);
        chk("rst_dout_en", 32'(o_mem_dout_en), 32'd0);
        chk("rst_strobes", 32'({o_mem_ce, o_mem_ub, o_mem_lb, o_mem_oe, o_mem_we}), 32'h1F);
        @(negedge clk);
        reset = 1'b0;

        push(0, mk(1'b0, 20'h00010, 16'h0000));
        drain();
        push(1, mk(1'b1, 20'h0FFFF, 16'h1234));
        drain();

        // Both ports held: exercises the tie rule on every grant.
        for (int i = 0; i < 4; i++) begin
            push(0, rand_txn());
            push(1, rand_txn());
        end
        drain();

        // Back-to-back writes from the CPU, then read both back.
        push(0, mk(1'b1, 20'h00001, 16'hA1A1));
        push(0, mk(1'b1, 20'h00002, 16'hB2B2));
        drain();
        push(1, mk(1'b0, 20'h00001, 16'h0000));
        push(1, mk(1'b0, 20'h00002, 16'h0000));
        drain();

        // Reset during the first strobe cycle of a write.
        push(0, mk(1'b1, 20'h00033, 16'hDEAD));
        step(1'b0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        inflight = -1;
        wait_cnt = 0;
        req = 2'b00;
        ref_mem[32'h33] = 16'hDEAD;
        rd_hold = '0;
`ifdef SRAM_ARB_RR_EN
        last = 1'b1;
`endif
        @(posedge clk);
        #1;
        chk("abort_strobes", 32'({o_mem_ce, o_mem_ub, o_mem_lb, o_mem_oe, o_mem_we}), 32'h1F);
        chk("abort_dout_en", 32'(o_mem_dout_en), 32'd0);
        chk("abort_ack", 32'({o_ack1, o_ack0}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        push(0, mk(1'b0, 20'h00033, 16'h0000));
        drain();

        repeat (1500) step(1'b1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
